// File: rtl/pc_pipeline.sv
// -----------------------------------------------------------------------------
// pc_pipeline
//
// Fetch-PC generator plus a PC/valid delay line for the 151 core. The block
// issues one fetch address per unstalled cycle and carries every fetched PC
// through DEPTH stages (stage 0 = decode), each tagged with a valid bit.
// A redirect (branch/jump) or a bubble (hazard) clears the valid bits of the
// youngest instructions, namely the fetch in flight and stages
// 0..FLUSH_DEPTH-2. Those instructions land in stages 0..FLUSH_DEPTH-1
// already invalid. Older stages keep flowing.
//
// Optional feature: define PC_PIPELINE_PERF_EN to build the cycle and
// retired-instruction counters. Without it the counter outputs read 0 and
// no counter flops exist.
//
// Ports
//   clk            clock
//   reset_n        synchronous reset, active-low
//   stall          global memory stall; every register in the block holds
//   redirect       next fetch comes from redirect_pc; kills young stages
//   redirect_pc    branch/jump target, XLEN bits
//   bubble         kill young stages without changing the fetch stream
//   icache_addr    address presented to the icache this cycle (combinational)
//   icache_re      fetch request (equal to reset_n)
//   pc_fetch       PC of the instruction on icache_dout this cycle
//   pc_stage       packed stage PCs; [k*XLEN +: XLEN] is stage k
//   valid_stage    bit k set when stage k holds a real instruction
//   cycle_count    posedges out of reset, stalls included (perf build only)
//   instret_count  instructions leaving the last stage (perf build only)
// -----------------------------------------------------------------------------
module pc_pipeline #(
  parameter int              XLEN         = 32,
  parameter int              DEPTH        = 3,
  parameter int              FLUSH_DEPTH  = 2,
  parameter int              INSTR_BYTES  = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_2000)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [XLEN-1:0]       redirect_pc,
  input  logic                  bubble,
  output logic [XLEN-1:0]       icache_addr,
  output logic                  icache_re,
  output logic [XLEN-1:0]       pc_fetch,
  output logic [DEPTH*XLEN-1:0] pc_stage,
  output logic [DEPTH-1:0]      valid_stage,
  output logic [31:0]           cycle_count,
  output logic [31:0]           instret_count
);

  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  // Stages that a redirect or bubble kills, as a constant bit mask.
  function automatic logic [DEPTH-1:0] make_flush_mask();
    logic [DEPTH-1:0] m;
    m = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < FLUSH_DEPTH) m[k] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [DEPTH-1:0] FLUSH_MASK = make_flush_mask();

  // pc_q holds the last issued fetch address. On the cycle after issue it
  // is the PC of the instruction that the icache returns.
  logic [XLEN-1:0]             pc_q;
  logic                        fetch_v_q;
  logic [DEPTH-1:0][XLEN-1:0]  pc_s;
  logic [DEPTH-1:0]            v_s;

  logic                        kill;
  logic [XLEN-1:0]             seq_pc;

  assign kill   = redirect | bubble;
  assign seq_pc = pc_q + STEP;     // wraps silently at 2^XLEN

  // Next fetch address. Reset forces the reset vector so that the icache
  // sees a sane address even though icache_re is low. A stall re-presents
  // the current address.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    icache_addr = seq_pc;
    if (!reset_n) begin
      icache_addr = RESET_VECTOR;
    end else if (stall) begin
      icache_addr = pc_q;
    end else if (redirect) begin
      icache_addr = redirect_pc;
    end
  end

  assign icache_re   = reset_n;
  assign pc_fetch    = pc_q;
  assign pc_stage    = pc_s;
  assign valid_stage = v_s;

  // Fetch register and stage delay line. Redirect and bubble take effect
  // only on unstalled edges. The requester holds them through a stall.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // stage samples the value its neighbour held before this edge.
    if (!reset_n) begin
      // pc_q starts one step before the vector, so the first sequential
      // fetch out of reset is RESET_VECTOR itself.
      pc_q      <= RESET_VECTOR - STEP;
      fetch_v_q <= 1'b0;
      // NOTE: the stage PCs are reset along with the valid bits because
      // downstream logic reads pc_stage as 0 straight out of reset. Outside
      // that window, the PC of an invalid stage carries no meaning.
      pc_s      <= '0;
      v_s       <= '0;
    end else if (!stall) begin
      pc_q      <= icache_addr;
      fetch_v_q <= 1'b1;
      pc_s[0]   <= pc_q;
      v_s[0]    <= fetch_v_q & ~(kill & FLUSH_MASK[0]);
      for (int k = 1; k < DEPTH; k++) begin
        pc_s[k] <= pc_s[k-1];
        v_s[k]  <= v_s[k-1] & ~(kill & FLUSH_MASK[k]);
      end
    end
  end

`ifdef PC_PIPELINE_PERF_EN
  logic [31:0] cycle_q;
  logic [31:0] instret_q;

  // cycle_q counts every edge out of reset, including stalled edges.
  // instret_q counts a retirement only when the last stage really advances.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (!stall && v_s[DEPTH-1]) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`else
  assign cycle_count   = '0;
  assign instret_count = '0;
`endif

endmodule

// File: tb/tb_pc_pipeline.sv
// -----------------------------------------------------------------------------
// tb_pc_pipeline
//
// Three pc_pipeline instances share one stimulus stream:
//   inst 0 "m"  defaults (DEPTH=3, FLUSH_DEPTH=2, vector 0x2000)
//   inst 1 "b"  DEPTH=4, FLUSH_DEPTH=1
//   inst 2 "w"  RESET_VECTOR=0xFFFF_FFFC (address wrap)
// The reference model treats each pipeline as a list of fetched
// instructions, ordered youngest first. Entry 0 is the fetch in flight and
// entry k+1 is stage k. A kill marks the FLUSH_DEPTH youngest entries as
// dead.
// -----------------------------------------------------------------------------
module tb_pc_pipeline;

  localparam int NI   = 3;
  localparam int MAXD = 4;

`ifdef PC_PIPELINE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, stall, redirect, bubble;
  logic [31:0] redirect_pc;

  logic [31:0]  m_addr, m_fetch, m_cyc, m_ret;
  logic         m_re;
  logic [95:0]  m_stage;
  logic [2:0]   m_vld;
  logic [31:0]  b_addr, b_fetch, b_cyc, b_ret;
  logic         b_re;
  logic [127:0] b_stage;
  logic [3:0]   b_vld;
  logic [31:0]  w_addr, w_fetch, w_cyc, w_ret;
  logic         w_re;
  logic [95:0]  w_stage;
  logic [2:0]   w_vld;

  pc_pipeline dut_m (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .bubble(bubble), .icache_addr(m_addr),
    .icache_re(m_re), .pc_fetch(m_fetch), .pc_stage(m_stage),
    .valid_stage(m_vld), .cycle_count(m_cyc), .instret_count(m_ret));

  pc_pipeline #(.DEPTH(4), .FLUSH_DEPTH(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .bubble(bubble), .icache_addr(b_addr),
    .icache_re(b_re), .pc_fetch(b_fetch), .pc_stage(b_stage),
    .valid_stage(b_vld), .cycle_count(b_cyc), .instret_count(b_ret));

  pc_pipeline #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .bubble(bubble), .icache_addr(w_addr),
    .icache_re(w_re), .pc_fetch(w_fetch), .pc_stage(w_stage),
    .valid_stage(w_vld), .cycle_count(w_cyc), .instret_count(w_ret));

  // Observed outputs gathered per instance.
  logic [31:0]        o_addr[NI], o_fetch[NI], o_cyc[NI], o_ret[NI];
  logic               o_re[NI];
  logic [MAXD-1:0]    o_vld[NI];
  logic [MAXD*32-1:0] o_stage[NI];

  always_comb begin
    o_addr[0]  = m_addr;  o_addr[1]  = b_addr;  o_addr[2]  = w_addr;
    o_fetch[0] = m_fetch; o_fetch[1] = b_fetch; o_fetch[2] = w_fetch;
    o_cyc[0]   = m_cyc;   o_cyc[1]   = b_cyc;   o_cyc[2]   = w_cyc;
    o_ret[0]   = m_ret;   o_ret[1]   = b_ret;   o_ret[2]   = w_ret;
    o_re[0]    = m_re;    o_re[1]    = b_re;    o_re[2]    = w_re;
    o_vld[0]   = {1'b0, m_vld};
    o_vld[1]   = b_vld;
    o_vld[2]   = {1'b0, w_vld};
    o_stage[0] = {32'h0, m_stage};
    o_stage[1] = b_stage;
    o_stage[2] = {32'h0, w_stage};
  end

  function automatic int cfg_depth(input int i);
    return (i == 1) ? 4 : 3;
  endfunction
  function automatic int cfg_flush(input int i);
    return (i == 1) ? 1 : 2;
  endfunction
  function automatic logic [31:0] cfg_rv(input int i);
    return (i == 2) ? 32'hFFFF_FFFC : 32'h0000_2000;
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mh_pc[NI][MAXD+1];
  bit          mh_v [NI][MAXD+1];
  logic [31:0] mc_cyc[NI], mc_ret[NI];
  bit          model_live = 1'b0;

  task automatic model_reset(input int i);
    for (int k = 0; k <= MAXD; k++) begin
      mh_pc[i][k] = 32'h0;
      mh_v[i][k]  = 1'b0;
    end
    mh_pc[i][0] = cfg_rv(i) - 32'd4;
    mc_cyc[i]   = 32'h0;
    mc_ret[i]   = 32'h0;
  endtask

  function automatic logic [31:0] model_addr(input int i);
    if (!reset_n)  return cfg_rv(i);
    if (stall)     return mh_pc[i][0];
    if (redirect)  return redirect_pc;
    return mh_pc[i][0] + 32'd4;
  endfunction

  task automatic model_step(input int i);
    int d;
    logic [31:0] nxt;
    d = cfg_depth(i);
    if (!reset_n) begin
      model_reset(i);
    end else begin
      mc_cyc[i] = mc_cyc[i] + 32'd1;
      if (!stall) begin
        nxt = model_addr(i);
        if (mh_v[i][d]) mc_ret[i] = mc_ret[i] + 32'd1;
        if (redirect || bubble)
          for (int j = 0; j < cfg_flush(i); j++) mh_v[i][j] = 1'b0;
        // The oldest instruction leaves and the new fetch joins as youngest.
        for (int j = d; j > 0; j--) begin
          mh_pc[i][j] = mh_pc[i][j-1];
          mh_v[i][j]  = mh_v[i][j-1];
        end
        mh_pc[i][0] = nxt;
        mh_v[i][0]  = 1'b1;
      end
    end
  endtask

  task automatic check_model(input int i);
    logic [MAXD-1:0]    ev;
    logic [MAXD*32-1:0] ep, mask;
    ev = '0; ep = '0; mask = '0;
    for (int k = 0; k < cfg_depth(i); k++) begin
      ev[k] = mh_v[i][k+1];
      if (mh_v[i][k+1]) begin
        ep[k*32 +: 32]   = mh_pc[i][k+1];
        mask[k*32 +: 32] = '1;
      end
    end
    check($sformatf("inst%0d icache_re", i), 128'(o_re[i]), 128'(reset_n));
    check($sformatf("inst%0d icache_addr", i), 128'(o_addr[i]), 128'(model_addr(i)));
    check($sformatf("inst%0d pc_fetch", i), 128'(o_fetch[i]), 128'(mh_pc[i][0]));
    check($sformatf("inst%0d valid_stage", i), 128'(o_vld[i]), 128'(ev));
    check($sformatf("inst%0d pc_stage", i), 128'(o_stage[i] & mask), 128'(ep));
    check($sformatf("inst%0d cycle_count", i), 128'(o_cyc[i]),
          128'(PERF ? mc_cyc[i] : 32'h0));
    check($sformatf("inst%0d instret_count", i), 128'(o_ret[i]),
          128'(PERF ? mc_ret[i] : 32'h0));
  endtask

  // One clock: check mid-cycle, then advance DUTs and model together.
  task automatic tick();
    #3;
    if (model_live) for (int i = 0; i < NI; i++) check_model(i);
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    #1;
  endtask

  task automatic set_in(input bit s, input bit r, input bit b,
                        input logic [31:0] rpc);
    stall = s; redirect = r; bubble = b; redirect_pc = rpc;
  endtask

  // One reset edge with stall and redirect also asserted (reset must win),
  // followed by release with all requests idle.
  task automatic do_reset();
    reset_n = 1'b0;
    set_in(1'b1, 1'b1, 1'b1, 32'h0000_9000);
    tick();
    reset_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- directed vectors for instance m ----------------
  typedef struct {
    bit          stall;
    bit          redirect;
    bit          bubble;
    logic [31:0] rpc;
    logic [31:0] e_addr;
    logic [31:0] e_fetch;
    logic [2:0]  e_v;
    logic [31:0] e_pc0;   // checked only when e_v[0] is set
  } vec_t;

  vec_t vec[17];

  initial begin
    // stall redir bubble rpc         addr          fetch         v     pc0
    vec[0]  = '{0, 0, 0, 32'h0,    32'h2000, 32'h1FFC, 3'b000, 32'h0};
    vec[1]  = '{0, 0, 0, 32'h0,    32'h2004, 32'h2000, 3'b000, 32'h0};
    vec[2]  = '{0, 0, 0, 32'h0,    32'h2008, 32'h2004, 3'b001, 32'h2000};
    vec[3]  = '{1, 0, 0, 32'h0,    32'h2008, 32'h2008, 3'b011, 32'h2004};
    vec[4]  = '{1, 0, 0, 32'h0,    32'h2008, 32'h2008, 3'b011, 32'h2004};
    vec[5]  = '{1, 0, 0, 32'h0,    32'h2008, 32'h2008, 3'b011, 32'h2004};
    vec[6]  = '{0, 0, 0, 32'h0,    32'h200C, 32'h2008, 3'b011, 32'h2004};
    vec[7]  = '{0, 1, 0, 32'h2100, 32'h2100, 32'h200C, 3'b111, 32'h2008};
    vec[8]  = '{0, 0, 0, 32'h0,    32'h2104, 32'h2100, 3'b100, 32'h0};
    vec[9]  = '{0, 0, 0, 32'h0,    32'h2108, 32'h2104, 3'b001, 32'h2100};
    vec[10] = '{0, 1, 1, 32'h3000, 32'h3000, 32'h2108, 3'b011, 32'h2104};
    vec[11] = '{0, 1, 0, 32'h4000, 32'h4000, 32'h3000, 3'b100, 32'h0};
    vec[12] = '{0, 0, 1, 32'h0,    32'h4004, 32'h4000, 3'b000, 32'h0};
    vec[13] = '{1, 1, 0, 32'h5000, 32'h4004, 32'h4004, 3'b000, 32'h0};
    vec[14] = '{0, 0, 0, 32'h0,    32'h4008, 32'h4004, 3'b000, 32'h0};
    vec[15] = '{0, 0, 0, 32'h0,    32'h400C, 32'h4008, 3'b001, 32'h4004};
    vec[16] = '{0, 0, 0, 32'h0,    32'h4010, 32'h400C, 3'b011, 32'h4008};

    // Power-up reset: two edges before the model is trusted.
    reset_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    model_live = 1'b1;
    #2;
    check("reset icache_re", 128'(m_re), 128'(1'b0));
    check("reset icache_addr", 128'(m_addr), 128'(32'h2000));
    check("reset pc_fetch", 128'(m_fetch), 128'(32'h1FFC));
    check("reset valid_stage", 128'(m_vld), 128'(3'b000));
    check("reset pc_stage", 128'(m_stage), 128'(96'h0));
    check("reset cycle_count", 128'(m_cyc), 128'(32'h0));
    check("reset instret_count", 128'(m_ret), 128'(32'h0));
    tick();

    // Table-driven sequence: release, stall, redirect, bubble, stalled redirect.
    reset_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_in(vec[i].stall, vec[i].redirect, vec[i].bubble, vec[i].rpc);
      #2;
      check($sformatf("vec%0d icache_addr", i), 128'(m_addr), 128'(vec[i].e_addr));
      check($sformatf("vec%0d pc_fetch", i), 128'(m_fetch), 128'(vec[i].e_fetch));
      check($sformatf("vec%0d valid_stage", i), 128'(m_vld), 128'(vec[i].e_v));
      if (vec[i].e_v[0])
        check($sformatf("vec%0d pc_s0", i), 128'(m_stage[31:0]), 128'(vec[i].e_pc0));
      tick();
    end

    // Reset wins over a simultaneous stall and redirect. Then a bubble on
    // DEPTH=4, FLUSH_DEPTH=1 clears only stage 0.
    do_reset();
    #2;
    check("post-reset addr (redirect dropped)", 128'(m_addr), 128'(32'h2000));
    check("post-reset b valid", 128'(b_vld), 128'(4'b0000));
    for (int n = 0; n < 6; n++) tick();
    #2;
    check("b full valid", 128'(b_vld), 128'(4'b1111));
    set_in(1'b0, 1'b0, 1'b1, 32'h0);
    #1;
    check("b addr during bubble", 128'(b_addr), 128'(32'h2018));
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    check("b valid after bubble", 128'(b_vld), 128'(4'b1110));
    check("b addr after bubble", 128'(b_addr), 128'(32'h201C));
    tick();
    #2;
    check("b bubble moves down", 128'(b_vld), 128'(4'b1101));
    tick();

    // Reset vector at the top of the address space wraps to 0.
    do_reset();
    #2;
    check("wrap first addr", 128'(w_addr), 128'(32'hFFFF_FFFC));
    tick();
    #2;
    check("wrap second addr", 128'(w_addr), 128'(32'h0000_0000));
    tick();
    #2;
    check("wrap pc_fetch", 128'(w_fetch), 128'(32'h0000_0000));

    // Counters: fill for 6 edges, then a 10-edge window containing
    // stall, bubble, bubble, 6 plain edges, stall. 5 retire in the window.
    do_reset();
    for (int n = 0; n < 6; n++) tick();
    #2;
    check("fill cycle_count", 128'(m_cyc), 128'(PERF ? 32'd6 : 32'd0));
    check("fill instret_count", 128'(m_ret), 128'(PERF ? 32'd2 : 32'd0));
    for (int n = 0; n < 10; n++) begin
      set_in(n == 0 || n == 9, 1'b0, n == 1 || n == 2, 32'h0);
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    check("window cycle_count", 128'(m_cyc), 128'(PERF ? 32'd16 : 32'd0));
    check("window instret_count", 128'(m_ret), 128'(PERF ? 32'd7 : 32'd0));

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      reset_n  = ($urandom_range(0, 63) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 5) == 0);
      bubble   = ($urandom_range(0, 5) == 0);
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) redirect_pc = 32'hFFFF_FFF8;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
